// File: rtl/exec_pkg.sv
// Shared definitions for the exec_seq execute stage: opcodes, FSM states,
// and the zero/carry flag helper.
package exec_pkg;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_LDL = 4'h3;
  localparam logic [3:0] OP_LDH = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_NOP = 4'hD;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StMul  = 1'b1
  } exec_state_e;

  typedef struct packed {
    logic z;
    logic c;
  } flags_t;

  // Result is zero-extended by the caller; data widths up to 64 bits.
  function automatic flags_t calc_flags(input logic [63:0] result, input logic carry);
    flags_t f;
    f.z = (result == 64'd0);
    f.c = carry;
    return f;
  endfunction

endpackage

// File: rtl/exec_mul_seq.sv
// Sequential shift-add multiplier: one partial product per clock.
// 'product' is the combinational next accumulator value, so when 'done' is high
// it already holds the full product for the caller to register on that edge.
module exec_mul_seq #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk_ex,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [2*DATA_W-1:0] acc_q, acc_d, mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [CntW-1:0]     cnt_q;
  logic                run_q;

  // Add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  assign done    = run_q && (cnt_q == CntW'(DATA_W - 1));
  assign product = acc_d;

  // Operand latch on start, then one shift-add step per cycle.
  always_ff @(posedge clk_ex or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{DATA_W{1'b0}}, op_a};
      mplier_q <= op_b;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CntW'(1);
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_seq.sv
// Execute stage: write-back data, flags and next PC from a decoded opcode.
// Optional multi-cycle multiply is enabled by defining EXEC_MUL_EN; otherwise
// opcode C is a NOP and busy is tied low.
module exec_seq
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned IMM_W  = 8
) (
  input  logic              clk_ex,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] reg_b,
  input  logic [IMM_W-1:0]  op_data,
  output logic [PC_W-1:0]   p_count,
  output logic [DATA_W-1:0] reg_in,
  output logic              reg_we,
  output logic              flag_z,
  output logic              flag_c,
  output logic              busy
);

  localparam int unsigned ExtW = (PC_W > IMM_W) ? PC_W : IMM_W;

  exec_state_e       state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc, jmp_tgt;
  logic [DATA_W-1:0] reg_in_q, reg_in_d;
  logic              we_q, we_d;
  logic              z_q, z_d, c_q, c_d;
  logic [ExtW-1:0]   imm_ext;
  logic [DATA_W:0]   add_full;
  logic [DATA_W-1:0] sub_res, and_res, or_res, shl_res, shr_res;

  assign pc_inc   = pc_q + PC_W'(1);
  // Jump target: immediate zero-extended or truncated to the PC width.
  assign imm_ext  = ExtW'(op_data);
  assign jmp_tgt  = imm_ext[PC_W-1:0];
  assign add_full = {1'b0, reg_a} + {1'b0, reg_b};
  assign sub_res  = reg_a - reg_b;
  assign and_res  = reg_a & reg_b;
  assign or_res   = reg_a | reg_b;
  assign shl_res  = {reg_a[DATA_W-2:0], 1'b0};
  assign shr_res  = {1'b0, reg_a[DATA_W-1:1]};

`ifdef EXEC_MUL_EN
  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_prod;

  exec_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk_ex  (clk_ex),
    .reset   (reset),
    .start   (mul_start),
    .op_a    (reg_a),
    .op_b    (reg_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign busy = (state_q == StMul);
`else
  assign busy = 1'b0;
`endif

  // Next-state, write-back and flag selection; everything holds by default.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    reg_in_d = reg_in_q;
    we_d     = 1'b0;
    z_d      = z_q;
    c_d      = c_q;
`ifdef EXEC_MUL_EN
    mul_start = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          pc_d = pc_inc;
          case (op_code)
            OP_MOV: begin
              reg_in_d = reg_b;
              we_d     = 1'b1;
            end
            OP_ADD: begin
              reg_in_d   = add_full[DATA_W-1:0];
              we_d       = 1'b1;
              {z_d, c_d} = calc_flags(64'(add_full[DATA_W-1:0]), add_full[DATA_W]);
            end
            OP_SUB: begin
              reg_in_d   = sub_res;
              we_d       = 1'b1;
              {z_d, c_d} = calc_flags(64'(sub_res), reg_a < reg_b);
            end
            OP_LDL: begin
              reg_in_d = {reg_a[DATA_W-1:IMM_W], op_data};
              we_d     = 1'b1;
            end
            OP_LDH: begin
              reg_in_d = {op_data, reg_a[IMM_W-1:0]};
              we_d     = 1'b1;
            end
            OP_AND: begin
              reg_in_d   = and_res;
              we_d       = 1'b1;
              {z_d, c_d} = calc_flags(64'(and_res), 1'b0);
            end
            OP_OR: begin
              reg_in_d   = or_res;
              we_d       = 1'b1;
              {z_d, c_d} = calc_flags(64'(or_res), 1'b0);
            end
            OP_SHL: begin
              reg_in_d   = shl_res;
              we_d       = 1'b1;
              {z_d, c_d} = calc_flags(64'(shl_res), reg_a[DATA_W-1]);
            end
            OP_SHR: begin
              reg_in_d   = shr_res;
              we_d       = 1'b1;
              {z_d, c_d} = calc_flags(64'(shr_res), reg_a[0]);
            end
            OP_JMP: pc_d = jmp_tgt;
            OP_JZ:  if (z_q) pc_d = jmp_tgt;
            OP_JC:  if (c_q) pc_d = jmp_tgt;
`ifdef EXEC_MUL_EN
            OP_MUL: begin
              // PC holds until the product is written back.
              pc_d      = pc_q;
              mul_start = 1'b1;
              state_d   = StMul;
            end
`endif
            default: ;
          endcase
        end
      end
      StMul: begin
`ifdef EXEC_MUL_EN
        if (mul_done) begin
          reg_in_d   = mul_prod[DATA_W-1:0];
          we_d       = 1'b1;
          pc_d       = pc_inc;
          {z_d, c_d} = calc_flags(64'(mul_prod[DATA_W-1:0]),
                                  |mul_prod[2*DATA_W-1:DATA_W]);
          state_d    = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk_ex or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      reg_in_q <= '0;
      we_q     <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      reg_in_q <= reg_in_d;
      we_q     <= we_d;
      z_q      <= z_d;
      c_q      <= c_d;
    end
  end

  assign p_count = pc_q;
  assign reg_in  = reg_in_q;
  assign reg_we  = we_q;
  assign flag_z  = z_q;
  assign flag_c  = c_q;

endmodule

// File: tb/tb_exec_seq.sv
// Scoreboard bench for exec_seq: stimulus pushes the expected post-edge
// outputs per cycle, a monitor pops and compares one entry after each edge.
module tb_exec_seq;

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 8;
  localparam int unsigned IW = 8;
`ifdef EXEC_MUL_EN
  localparam logic MulEn = 1'b1;
`else
  localparam logic MulEn = 1'b0;
`endif

  logic          clk_ex = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [3:0]    op_code;
  logic [DW-1:0] reg_a, reg_b;
  logic [IW-1:0] op_data;
  logic [PW-1:0] p_count;
  logic [DW-1:0] reg_in;
  logic          reg_we, flag_z, flag_c, busy;

  exec_seq #(
    .DATA_W (DW),
    .PC_W   (PW),
    .IMM_W  (IW)
  ) dut (
    .clk_ex   (clk_ex),
    .reset    (reset),
    .valid_in (valid_in),
    .op_code  (op_code),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .op_data  (op_data),
    .p_count  (p_count),
    .reg_in   (reg_in),
    .reg_we   (reg_we),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .busy     (busy)
  );

  always #5 clk_ex = ~clk_ex;

  typedef struct {
    string         nm;
    logic [PW-1:0] pc;
    logic [DW-1:0] rin;
    logic          we, z, c, bsy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Drive one cycle of inputs (at negedge) and queue the outputs expected after the next edge.
  task automatic cyc(input logic rst, input logic v, input logic [3:0] op,
                     input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [IW-1:0] imm,
                     input string nm, input logic [PW-1:0] pc, input logic [DW-1:0] rin,
                     input logic we, input logic z, input logic c, input logic bsy);
    exp_t e;
    @(negedge clk_ex);
    reset    = rst;
    valid_in = v;
    op_code  = op;
    reg_a    = a;
    reg_b    = b;
    op_data  = imm;
    e.nm = nm; e.pc = pc; e.rin = rin; e.we = we; e.z = z; e.c = c; e.bsy = bsy;
    sb.push_back(e);
  endtask

  // Monitor: compare every output one time unit after each rising edge.
  always @(posedge clk_ex) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      checks++;
      if ({p_count, reg_in, reg_we, flag_z, flag_c, busy} !==
          {mon_e.pc, mon_e.rin, mon_e.we, mon_e.z, mon_e.c, mon_e.bsy}) begin
        errors++;
        $display("FAIL %s: got pc=%h rin=%h we=%b z=%b c=%b busy=%b, want pc=%h rin=%h we=%b z=%b c=%b busy=%b",
                 mon_e.nm, p_count, reg_in, reg_we, flag_z, flag_c, busy,
                 mon_e.pc, mon_e.rin, mon_e.we, mon_e.z, mon_e.c, mon_e.bsy);
      end
    end
  end

  initial begin
    reset = 1'b0; valid_in = 1'b1; op_code = 4'h1;
    reg_a = 16'hFFFF; reg_b = 16'h0001; op_data = 8'hAA;

    // Reset held with live stimulus, then released.
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 4'h1, 16'hFFFF, 16'h0001, 8'hAA, "reset_hold", 8'h00, 16'h0000, 0, 0, 0, 0);
    cyc(1, 0, 4'h1, 16'h0, 16'h0, 8'h0, "reset_release", 8'h00, 16'h0000, 0, 0, 0, 0);

    cyc(1, 1, 4'h1, 16'hFFFF, 16'h0001, 8'h00, "add_wrap", 8'h01, 16'h0000, 1, 1, 1, 0);
    cyc(1, 1, 4'h2, 16'h0003, 16'h0005, 8'h00, "sub_borrow", 8'h02, 16'hFFFE, 1, 0, 1, 0);
    cyc(1, 1, 4'h3, 16'h1234, 16'h0000, 8'hAB, "ldl", 8'h03, 16'h12AB, 1, 0, 1, 0);
    cyc(1, 1, 4'h4, 16'h1234, 16'h0000, 8'hAB, "ldh", 8'h04, 16'hAB34, 1, 0, 1, 0);
    cyc(1, 1, 4'h2, 16'h0005, 16'h0005, 8'h00, "sub_zero", 8'h05, 16'h0000, 1, 1, 0, 0);
    cyc(1, 1, 4'hA, 16'h0000, 16'h0000, 8'h40, "jz_taken", 8'h40, 16'h0000, 0, 1, 0, 0);
    cyc(1, 1, 4'hB, 16'h0000, 16'h0000, 8'h10, "jc_not_taken", 8'h41, 16'h0000, 0, 1, 0, 0);
    cyc(1, 1, 4'h5, 16'hF0F0, 16'h0FF0, 8'h00, "and", 8'h42, 16'h00F0, 1, 0, 0, 0);
    cyc(1, 1, 4'h6, 16'h0000, 16'h0000, 8'h00, "or_zero", 8'h43, 16'h0000, 1, 1, 0, 0);
    cyc(1, 1, 4'h7, 16'h8001, 16'h0000, 8'h00, "shl_carry", 8'h44, 16'h0002, 1, 0, 1, 0);
    cyc(1, 1, 4'h8, 16'h0001, 16'h0000, 8'h00, "shr_carry_zero", 8'h45, 16'h0000, 1, 1, 1, 0);
    cyc(1, 1, 4'hB, 16'h0000, 16'h0000, 8'h20, "jc_taken", 8'h20, 16'h0000, 0, 1, 1, 0);
    cyc(1, 1, 4'hA, 16'h0000, 16'h0000, 8'h30, "jz_taken2", 8'h30, 16'h0000, 0, 1, 1, 0);
    cyc(1, 1, 4'h0, 16'h1111, 16'hBEEF, 8'h00, "mov", 8'h31, 16'hBEEF, 1, 1, 1, 0);
    cyc(1, 1, 4'h8, 16'h0002, 16'h0000, 8'h00, "shr", 8'h32, 16'h0001, 1, 0, 0, 0);

    if (MulEn) begin
      // 0x0100 * 0x0101 = 0x1_0100: low half 0x0100, high half nonzero.
      cyc(1, 1, 4'hC, 16'h0100, 16'h0101, 8'h00, "mul_accept", 8'h32, 16'h0001, 0, 0, 0, 1);
      for (int i = 0; i < 15; i++)
        cyc(1, 1, 4'(i), DW'($urandom), DW'($urandom), IW'($urandom),
            "mul_busy", 8'h32, 16'h0001, 0, 0, 0, 1);
      cyc(1, 1, 4'h9, 16'h0000, 16'h0000, 8'h77, "mul_done", 8'h33, 16'h0100, 1, 0, 1, 0);
    end else begin
      cyc(1, 1, 4'hC, 16'h0100, 16'h0101, 8'h00, "op_c_nop", 8'h33, 16'h0001, 0, 0, 0, 0);
    end

    cyc(1, 1, 4'h9, 16'h0000, 16'h0000, 8'hFF, "jmp_ff", 8'hFF,
        MulEn ? 16'h0100 : 16'h0001, 0, 0, MulEn, 0);
    cyc(1, 1, 4'h0, 16'h0000, 16'h1357, 8'h00, "pc_wrap", 8'h00, 16'h1357, 1, 0, MulEn, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 4'h1, 16'hFFFF, 16'hFFFF, 8'h55, "idle_hold", 8'h00, 16'h1357, 0, 0, MulEn, 0);
    cyc(1, 1, 4'hE, 16'hFFFF, 16'hFFFF, 8'h55, "nop_e", 8'h01, 16'h1357, 0, 0, MulEn, 0);

    // Multiply interrupted by reset: nothing must ever be written back.
    cyc(1, 1, 4'hC, 16'h0003, 16'h0004, 8'h00, "mul2_issue",
        MulEn ? 8'h01 : 8'h02, 16'h1357, 0, 0, MulEn, MulEn);
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 4'h0, 16'h0000, 16'h0000, 8'h00, "mul2_wait",
          MulEn ? 8'h01 : 8'h02, 16'h1357, 0, 0, MulEn, MulEn);
    cyc(0, 0, 4'h0, 16'h0000, 16'h0000, 8'h00, "reset_mid_mul", 8'h00, 16'h0000, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      cyc(1, 0, 4'h0, 16'h0000, 16'h0000, 8'h00, "mul_aborted", 8'h00, 16'h0000, 0, 0, 0, 0);

    @(negedge clk_ex);
    @(negedge clk_ex);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
